// File: rtl/tweezer_dac_pkg.sv
// Shared state encoding, frame sizing and default DAC command for the
// tweezer DAC SPI transmitter.
package tweezer_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

  // DAC "write input register and update output" command
  localparam logic [7:0] DAC_CMD_WRITE_UPDATE = 8'h30;

  function automatic int unsigned frame_bits(input int unsigned cmd_bits,
                                             input int unsigned data_width);
    return cmd_bits + data_width;
  endfunction

  // Width of a down-counter that holds values 0 .. n-1
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tweezer_dac_spi_tx_timer.sv
// SCLK half-period tick generator: down-counter modulo DIV with synchronous
// restart; tick is high for one cycle at terminal count.
module spi_half_period_timer
  import tweezer_dac_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      cnt <= LOAD;
    end else if (cnt == '0) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/tweezer_dac_spi_tx.sv
// SPI transmitter for the tweezer controller feedback word: {CMD_WORD, sample}
// MSB first, one pending slot, saturating overrun count.
// Optional LDAC strobe output is enabled by defining TWEEZER_DAC_LDAC_EN.
//
//   state | meaning
//   IDLE  | nothing in flight, cs_n high
//   SETUP | cs_n low, first bit on mosi, sclk low for one half-period
//   SHIFT | sclk toggling each half-period, mosi advances on falling edges
//   GAP   | cs_n high for the inter-frame gap, pending sample launches after
module tweezer_dac_spi_tx
  import tweezer_dac_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH    = 16,
  parameter int unsigned         CMD_BITS      = 8,
  parameter logic [CMD_BITS-1:0] CMD_WORD      = CMD_BITS'(DAC_CMD_WRITE_UPDATE),
  parameter int unsigned         SCLK_DIV      = 2,
  parameter int unsigned         CS_GAP        = 4,
  parameter int unsigned         OFFSET_BINARY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  dac_sclk,
  output logic                  dac_mosi,
  output logic                  dac_cs_n,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           overrun_count
`ifdef TWEEZER_DAC_LDAC_EN
  ,
  output logic                  dac_ldac_n
`endif
);

  localparam int unsigned FB = frame_bits(CMD_BITS, DATA_WIDTH);
`ifdef TWEEZER_DAC_LDAC_EN
  // GAP must cover the whole LDAC pulse before the next frame starts
  localparam int unsigned GAP_LEN = (CS_GAP > SCLK_DIV) ? CS_GAP : SCLK_DIV + 1;
`else
  localparam int unsigned GAP_LEN = CS_GAP;
`endif
  localparam int unsigned BW = $clog2(FB + 1);
  localparam int unsigned GW = cnt_width(GAP_LEN);
  localparam logic [BW-1:0] BITS_LOAD = BW'(FB);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] CONV_MASK =
    (OFFSET_BINARY != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;

  tx_state_e             state;
  logic [FB-1:0]         shreg;
  logic [FB-1:0]         frame_new;
  logic [BW-1:0]         bits_left;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] pend_data;
  logic [DATA_WIDTH-1:0] src;
  logic                  pend_valid;
  logic                  start;
  logic                  restart;
  logic                  tick;

  // A sample arriving on the last GAP cycle takes precedence over pending
  always_comb begin
    src       = (state == IDLE || sample_valid) ? sample_in : pend_data;
    frame_new = {CMD_WORD, src ^ CONV_MASK};
    start     = ((state == IDLE) && sample_valid) ||
                ((state == GAP) && (gap_cnt == '0) && (sample_valid || pend_valid));
    restart   = (state == IDLE) || (state == GAP);
  end

  spi_half_period_timer #(
    .DIV (SCLK_DIV)
  ) u_half_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      dac_cs_n      <= 1'b1;
      dac_sclk      <= 1'b0;
      dac_mosi      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun_count <= '0;
      shreg         <= '0;
      bits_left     <= '0;
      gap_cnt       <= '0;
      pend_data     <= '0;
      pend_valid    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (sample_valid && (state != IDLE)) begin
        pend_data  <= sample_in;
        pend_valid <= 1'b1;
        if (pend_valid && (overrun_count != 16'hFFFF)) begin
          overrun_count <= overrun_count + 16'd1;
        end
      end

      if (start) begin
        state      <= SETUP;
        busy       <= 1'b1;
        dac_cs_n   <= 1'b0;
        dac_sclk   <= 1'b0;
        shreg      <= frame_new;
        dac_mosi   <= frame_new[FB-1];
        bits_left  <= BITS_LOAD;
        pend_valid <= 1'b0;
      end else begin
        case (state)
          SETUP: begin
            if (tick) begin
              dac_sclk <= 1'b1;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (tick) begin
              if (dac_sclk) begin
                dac_sclk  <= 1'b0;
                shreg     <= shreg << 1;
                dac_mosi  <= shreg[FB-2];
                bits_left <= bits_left - 1'b1;
              end else if (bits_left == '0) begin
                dac_cs_n   <= 1'b1;
                dac_mosi   <= 1'b0;
                frame_done <= 1'b1;
                gap_cnt    <= GAP_LOAD;
                state      <= GAP;
              end else begin
                dac_sclk <= 1'b1;
              end
            end
          end
          GAP: begin
            if (gap_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TWEEZER_DAC_LDAC_EN
  localparam int unsigned LW = cnt_width(SCLK_DIV);
  localparam logic [LW-1:0] LDAC_LOAD = LW'(SCLK_DIV - 1);

  logic [LW-1:0] ldac_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dac_ldac_n <= 1'b1;
      ldac_cnt   <= '0;
    end else if (frame_done) begin
      dac_ldac_n <= 1'b0;
      ldac_cnt   <= LDAC_LOAD;
    end else if (!dac_ldac_n) begin
      if (ldac_cnt == '0) begin
        dac_ldac_n <= 1'b1;
      end else begin
        ldac_cnt <= ldac_cnt - 1'b1;
      end
    end
  end
`endif

endmodule
